// File: rtl/fir_mac_param.sv
// Time-multiplexed FIR filter: one MAC walks a circular delay line against
// host-loadable coefficients, then scales and saturates one output sample.
module fir_mac_param #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned COEF_W = 18,
  parameter int unsigned TAPS   = 64,
  parameter int unsigned SHIFT  = 16,
  parameter int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      flush,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_wdata,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      out_sat
);

  localparam int unsigned AW = $clog2(TAPS);
  localparam int unsigned PW = DATA_W + COEF_W;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] delay_q [TAPS];
  logic signed [COEF_W-1:0] coef_q  [TAPS];

  logic [AW-1:0]            wp_q, wp_d;
  logic [AW-1:0]            rp_q, rp_d;
  logic [AW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_sat_q, out_sat_d;

  logic                     is_idle_c;
  logic                     accept_c;
  logic                     flush_c;
  logic                     addr_ok_c;
  logic                     coef_wr_c;
  logic signed [PW-1:0]     prod_c;
  logic signed [ACC_W-1:0]  shifted_c;
  logic [ACC_W-DATA_W:0]    hi_c;
  logic [DATA_W-1:0]        sat_data_c;
  logic                     sat_flag_c;

  // Handshake and host-port qualification; flush wins over a sample offer.
  assign is_idle_c = (state_q == S_IDLE);
  assign flush_c   = is_idle_c && flush;
  assign accept_c  = is_idle_c && in_valid && !flush;
  assign coef_wr_c = is_idle_c && coef_we && addr_ok_c;
  assign in_ready  = is_idle_c && !flush && !rst;

  // Only non-power-of-two tap counts can see an out-of-range address.
  if (TAPS == (32'd1 << AW)) begin : g_addr_full
    assign addr_ok_c = 1'b1;
  end else begin : g_addr_chk
    assign addr_ok_c = ({1'b0, coef_addr} < (AW+1)'(TAPS));
  end

  assign prod_c = coef_q[k_q] * delay_q[rp_q];

  // Scale, then clamp when the bits above the output sign are not a pure sign extension.
  always_comb begin
    shifted_c  = acc_q >>> SHIFT;
    hi_c       = shifted_c[ACC_W-1:DATA_W-1];
    sat_data_c = shifted_c[DATA_W-1:0];
    sat_flag_c = 1'b0;
    if (!((&hi_c) || (~|hi_c))) begin
      sat_flag_c = 1'b1;
      if (shifted_c[ACC_W-1]) begin
        sat_data_c = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        sat_data_c = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end
  end

  // Sequencer: accept -> TAPS MAC cycles -> one output cycle.
  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          rp_d    = wp_q;
          wp_d    = (wp_q == LAST) ? '0 : wp_q + 1'b1;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod_c);
        k_d   = k_q + 1'b1;
        rp_d  = (rp_q == '0) ? LAST : rp_q - 1'b1;
        if (k_q == LAST) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_data_d  = sat_data_c;
        out_sat_d   = sat_flag_c;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // Delay line and coefficient storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        delay_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      if (flush_c) begin
        for (int unsigned i = 0; i < TAPS; i++) begin
          delay_q[i] <= '0;
        end
      end else if (accept_c) begin
        delay_q[wp_q] <= in_data;
      end
      if (coef_wr_c) begin
        coef_q[coef_addr] <= coef_wdata;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_mac_param.sv
// Scoreboard bench for fir_mac_param with a 6-tap, shift-by-3 build: a sample-history
// reference model predicts each result; a separate monitor checks what the filter emits.
module tb_fir_mac_param;

  localparam int unsigned DATA_W = 18;
  localparam int unsigned COEF_W = 18;
  localparam int unsigned TAPS   = 6;
  localparam int unsigned SHIFT  = 3;
  localparam int unsigned AW     = $clog2(TAPS);
  localparam int          DMAX   = 131071;
  localparam int          DMIN   = -131072;

  typedef struct {
    int     data;
    bit     sat;
    longint acc_edge;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_wdata = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_sat;

  int     checks = 0;
  int     errors = 0;
  longint edge_n = 0;

  int     m_coef [TAPS];
  int     m_hist [$];
  int     busy = 0;
  exp_t   exp_q [$];
  int     last_data = 0;
  bit     last_sat = 1'b0;
  bit     prev_valid = 1'b0;

  fir_mac_param #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_data(out_data), .out_valid(out_valid), .out_sat(out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  function automatic void model_clear();
    for (int i = 0; i < TAPS; i++) m_coef[i] = 0;
    m_hist.delete();
    for (int i = 0; i < TAPS; i++) m_hist.push_back(0);
    busy = 0;
    exp_q.delete();
  endfunction

  // Convolution of newest-first history with coefficients, then floor shift and clamp.
  function automatic exp_t model_result(longint acc_edge);
    exp_t   e;
    longint acc = 0;
    longint r;
    for (int k = 0; k < TAPS; k++) acc += longint'(m_coef[k]) * longint'(m_hist[k]);
    r = acc >>> SHIFT;
    e.acc_edge = acc_edge;
    if (r > DMAX) begin
      e.data = DMAX; e.sat = 1'b1;
    end else if (r < DMIN) begin
      e.data = DMIN; e.sat = 1'b1;
    end else begin
      e.data = int'(r); e.sat = 1'b0;
    end
    return e;
  endfunction

  // Reference model: decides what the coming clock edge does and predicts results.
  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = !rst && (busy == 0) && !flush;
    checks++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready at edge %0d: got %b want %b", edge_n, in_ready, exp_ready);
    end
    if (rst) begin
      model_clear();
    end else if (busy == 0) begin
      if (coef_we && (coef_addr < TAPS)) m_coef[coef_addr] = int'($signed(coef_wdata));
      if (flush) begin
        for (int i = 0; i < TAPS; i++) m_hist[i] = 0;
      end else if (in_valid) begin
        m_hist.push_front(int'($signed(in_data)));
        void'(m_hist.pop_back());
        exp_q.push_back(model_result(edge_n + 1));
        busy = TAPS + 1;
      end
    end else begin
      busy--;
    end
  end

  // Monitor: pops the scoreboard on every out_valid and checks output hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b data=%0d sat=%b want 0 0 0",
                 out_valid, $signed(out_data), out_sat);
      end
      last_data  = 0;
      last_sat   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL valid_pulse: out_valid high two cycles in a row at edge %0d", edge_n);
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: out_valid at edge %0d with nothing outstanding", edge_n);
        end else begin
          e = exp_q.pop_front();
          checks += 3;
          if (int'($signed(out_data)) != e.data) begin
            errors++;
            $display("FAIL out_data: got %0d want %0d", $signed(out_data), e.data);
          end
          if (out_sat !== e.sat) begin
            errors++;
            $display("FAIL out_sat: got %b want %b (data %0d)", out_sat, e.sat, e.data);
          end
          if (edge_n - e.acc_edge != longint'(TAPS + 1)) begin
            errors++;
            $display("FAIL latency: got %0d want %0d clocks", edge_n - e.acc_edge, TAPS + 1);
          end
          last_data = e.data;
          last_sat  = e.sat;
        end
      end else begin
        checks++;
        if (int'($signed(out_data)) != last_data || out_sat !== last_sat) begin
          errors++;
          $display("FAIL output_hold: got %0d/%b want %0d/%b",
                   $signed(out_data), out_sat, last_data, last_sat);
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (busy == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0d outstanding=%0d want 0 0", busy, exp_q.size());
    end
  endtask

  task automatic wcoef(input int a, input int v);
    coef_we    = 1'b1;
    coef_addr  = AW'(a);
    coef_wdata = COEF_W'(v);
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic send(input int d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Impulse through coefficients 1..6; out-of-range addresses must be ignored.
    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
    wcoef(6, 555);
    wcoef(7, 999);
    send(80);
    repeat (TAPS - 1) send(0);
    wait_idle();

    // Back-to-back offers with in_valid held high.
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = DATA_W'(int'($urandom_range(0, 4000)) - 2000);
      tick();
    end
    in_valid = 1'b0;
    wait_idle();

    // Positive and negative saturation.
    wcoef(0, DMAX);
    for (int k = 1; k < TAPS; k++) wcoef(k, 0);
    send(DMAX);
    send(DMIN);
    wait_idle();

    // Floor behaviour of the arithmetic shift.
    wcoef(0, 1);
    send(-5);
    send(3);
    send(-1);
    wait_idle();

    // A coefficient write during MAC must not land.
    wcoef(0, 64);
    send(0);
    coef_we = 1'b1; coef_addr = '0; coef_wdata = COEF_W'(7);
    repeat (3) tick();
    coef_we = 1'b0;
    wait_idle();
    send(1);
    wait_idle();

    // Flush clears history; flush also blocks a same-cycle sample.
    for (int k = 0; k < TAPS; k++) wcoef(k, 8 * (k + 1));
    repeat (TAPS) send(1000);
    wait_idle();
    in_valid = 1'b1; in_data = DATA_W'(500); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    send(8);
    repeat (TAPS - 1) send(0);
    wait_idle();

    // Reset in the middle of a computation.
    send(100);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    wait_idle();

    // Random traffic including host writes, flushes and full-range samples.
    for (int i = 0; i < 500; i++) begin
      in_valid   = ($urandom_range(0, 9) < 6);
      in_data    = DATA_W'(int'($urandom_range(0, 4000)) - 2000);
      if ($urandom_range(0, 9) == 0) in_data = DATA_W'($urandom);
      flush      = ($urandom_range(0, 19) == 0);
      coef_we    = ($urandom_range(0, 4) == 0);
      coef_addr  = AW'($urandom_range(0, 7));
      coef_wdata = COEF_W'(int'($urandom_range(0, 4000)) - 2000);
      if ($urandom_range(0, 15) == 0) coef_wdata = COEF_W'($urandom);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; coef_we = 1'b0;
    wait_idle();
    repeat (3) tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding results want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_param.md
# fir_mac_param

Parametrised, time-multiplexed FIR filter with one multiplier-accumulator, a circular delay line, run-time loadable coefficients and a saturating, scaled output. It is the next-generation filter stage of the signal chain: it accepts one sample per handshake, computes a TAPS-point convolution over TAPS clock cycles, and emits one filtered sample with an overflow flag. Coefficients are written by a host port instead of being fixed at synthesis.

## Interface
- DATA_W, 18: signed sample width, input and output.
- COEF_W, 18: signed coefficient width.
- TAPS, 64: number of taps, 2..256.
- SHIFT, 16: arithmetic right shift applied to the accumulator before saturation.
- ACC_W, DATA_W+COEF_W+clog2(TAPS): accumulator width. Must be at least DATA_W+COEF_W.

- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  signed input sample.
- in_valid  in  1  sample offered.
- in_ready  out  1  block idle and able to accept a sample.
- flush  in  1  synchronous; zeroes the delay line, honoured only in IDLE.
- coef_we  in  1  coefficient write strobe, honoured only in IDLE.
- coef_addr  in  clog2(TAPS)  tap index k.
- coef_wdata  in  COEF_W  signed coefficient value.
- out_data  out  DATA_W  signed filtered sample. Holds its value until the next result.
- out_valid  out  1  one-cycle pulse when out_data is updated.
- out_sat  out  1  qualified by out_valid; high when the result was clamped.

## Operation
- The state machine has three states: IDLE, MAC and OUT. in_ready = (state==IDLE).
- **Reset:** state=IDLE. Delay line, coefficients, accumulator, write pointer, out_data, out_valid and out_sat are all 0. in_ready goes to 1 after rst deasserts.
- **IDLE:**
  - On in_valid&&in_ready: write in_data to delay[wp], latch base=wp, wp<=wp+1 (mod TAPS), acc<=0, k<=0, go to MAC.
  - If flush is also high in that cycle, flush takes priority: the delay line is zeroed and the sample is not accepted. Drive in_ready=0 for that cycle.
- **MAC:** each cycle, acc <= acc + coef[k]*delay[(base-k) mod TAPS] as a full-precision signed product, sign-extended to ACC_W; k<=k+1. After the k=TAPS-1 term, go to OUT.
- **OUT:**
  - Compute r = acc >>> SHIFT (arithmetic shift).
  - If r > 2^(DATA_W-1)-1: out_data = max, out_sat=1.
  - If r < -2^(DATA_W-1): out_data = min, out_sat=1.
  - Otherwise out_data = r[DATA_W-1:0], out_sat=0.
  - out_valid=1 for that single cycle; go to IDLE.
- There is no output backpressure; the consumer must take out_data on the out_valid pulse.
- **Coefficient writes:**
  - In IDLE, coef[coef_addr] <= coef_wdata.
  - A write and a sample accept in the same cycle are both performed; the new coefficient is used by that computation.
  - coef_we is ignored outside IDLE, with no error indication.
- coef_addr >= TAPS (non-power-of-two TAPS): write is ignored.
- The delay line wraps modulo TAPS. Indexing must be correct for non-power-of-two TAPS.
- rst mid-MAC or mid-OUT: the computation is abandoned, everything clears as at reset, and no out_valid is issued.

## Timing
- Accept edge E0. MAC edges E1..E_TAPS. out_valid is high in the cycle following edge E_TAPS+1, i.e. latency TAPS+1 clocks from accept.
- in_ready reasserts in the same cycle out_valid is high. A back-to-back sample can be accepted on that edge, so throughput is one sample per TAPS+2 clocks.
- out_data and out_sat change only on the out_valid edge. out_valid is never high for two consecutive cycles.
- flush takes one cycle in IDLE. A sample offered the following cycle sees an all-zero history.

## Test plan
All scenarios use TAPS=8 and SHIFT=0 unless noted.
- **Impulse:** load coef = 1,2,3,4,0,0,0,0. Feed 100 then seven 0s. Outputs must be 100, 200, 300, 400, 0, 0, 0, 0, all with out_sat=0.
- **Latency and throughput:** hold in_valid=1 continuously.
  - Each out_valid must come exactly 9 clocks after its accept edge.
  - in_ready must be high 1 cycle in every 10.
  - Exactly one out_valid per accepted sample.
- **Saturation:**
  - coef[0]=131071, others 0, input 131071: out_data=131071, out_sat=1.
  - Input -131072 with coef[0]=131071: out_data=-131072, out_sat=1.
- **Scaling (SHIFT=16, default widths):** coef[0]=65536, input -5 gives out_data=-5. coef[0]=32768, input 3 gives out_data=1 (floor shift).
- **Coef write while busy:** write coef[0]=7 during MAC. It must be ignored, and the next impulse of 1 must return the old coef[0].
- **Reset and flush:**
  - Assert rst at MAC cycle 4: no out_valid, and all outputs are 0 while rst is high.
  - After filling history with 1000s, pulse flush: the next impulse response must contain only the coef*impulse terms, with no residue.
